// File: rtl/yacc_sb_writeback_unpacker_if.sv
// ----------------------------------------------------------------------------
// yacc_sb_writeback_unpacker_if
//
// Purpose:
//   Bundles the two valid/ready streams of the superblock write-back unpacker.
//   The input stream carries one evicted superblock from the replacement logic.
//   The output stream carries one uncompressed 64-byte block toward memory.
//
// Signals:
//   in_valid / in_ready   superblock handshake
//   in_index              set index of the evicted line
//   in_sbtag              superblock tag: [SBTAG_W-1:4] address tag, [3:0] ids/presence
//   in_cf                 compression class (00 none, 01 /2, 10 /4, 11 illegal)
//   in_half_vld           half-valid bits, used for class 01 only
//   in_data               packed superblock data
//   out_valid / out_ready block handshake
//   out_addr              full block address {tag, index, blockId, 6'b0}
//   out_data              uncompressed block, zero-extended
//   out_last              final block of the current superblock
//
// Modports:
//   master  producer/consumer side (replacement logic + memory port)
//   slave   the unpacker itself
// ----------------------------------------------------------------------------
interface yacc_sb_writeback_unpacker_if #(
    parameter int DATA_W  = 512,
    parameter int SBTAG_W = 25,
    parameter int IDX_W   = 3
);
    logic               in_valid;
    logic               in_ready;
    logic [IDX_W-1:0]   in_index;
    logic [SBTAG_W-1:0] in_sbtag;
    logic [1:0]         in_cf;
    logic [1:0]         in_half_vld;
    logic [DATA_W-1:0]  in_data;

    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_addr;
    logic [DATA_W-1:0]  out_data;
    logic               out_last;

    modport master (
        output in_valid, in_index, in_sbtag, in_cf, in_half_vld, in_data, out_ready,
        input  in_ready, out_valid, out_addr, out_data, out_last
    );

    modport slave (
        input  in_valid, in_index, in_sbtag, in_cf, in_half_vld, in_data, out_ready,
        output in_ready, out_valid, out_addr, out_data, out_last
    );
endinterface

// File: rtl/yacc_sb_writeback_unpacker.sv
// ----------------------------------------------------------------------------
// yacc_sb_writeback_unpacker
//
// Purpose:
//   Write-back side of the YACC compressed cache. Accepts one evicted
//   superblock, works out which compressed slots hold live blocks, and emits
//   each live block as an uncompressed, zero-extended 64-byte line with its
//   full 32-bit block address.
//
// Ports:
//   clock       rising-edge clock
//   reset_n     synchronous, active-low reset
//   bus         slave side of yacc_sb_writeback_unpacker_if (both streams)
//   wb_count    total blocks handed to memory (wraps)
//   drop_count  superblocks accepted with nothing to emit (saturates)
// ----------------------------------------------------------------------------
module yacc_sb_writeback_unpacker #(
    parameter int DATA_W  = 512,
    parameter int SBTAG_W = 25,
    parameter int IDX_W   = 3
) (
    input  logic                              clock,
    input  logic                              reset_n,
    yacc_sb_writeback_unpacker_if.slave       bus,
    output logic [31:0]                       wb_count,
    output logic [15:0]                       drop_count
);

    localparam int HALF_W = DATA_W / 2;
    localparam int QUAD_W = DATA_W / 4;

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_index;
    logic [SBTAG_W-1:0] r_sbtag;
    logic [1:0]         r_cf;
    logic [DATA_W-1:0]  r_data;
    logic [3:0]         r_mask;

    logic               r_in_ready;
    logic               r_out_valid;
    logic [31:0]        r_out_addr;
    logic [DATA_W-1:0]  r_out_data;
    logic               r_out_last;
    logic [31:0]        r_wb_count;
    logic [15:0]        r_drop_count;

    logic [3:0]         w_acc_mask;
    logic [3:0]         w_next_mask;

    // Index of the lowest pending slot; slots are always emitted in
    // ascending order, so this is the slot currently on the output.
    function automatic logic [1:0] lowSlot(input logic [3:0] mask);
        if (mask[0])      return 2'd0;
        else if (mask[1]) return 2'd1;
        else if (mask[2]) return 2'd2;
        else              return 2'd3;
    endfunction

    // Block address of the lowest pending slot. Class 01 keeps the ids of
    // both halves in the tag; class 10 uses the slot number as the id.
    function automatic logic [31:0] slotAddr(
        input logic [3:0]         mask,
        input logic [1:0]         cf,
        input logic [SBTAG_W-1:0] sbtag,
        input logic [IDX_W-1:0]   index
    );
        logic [1:0] k;
        logic [1:0] blockId;
        k = lowSlot(mask);
        case (cf)
            2'b01:   blockId = (k == 2'd0) ? sbtag[1:0] : sbtag[3:2];
            2'b10:   blockId = k;
            default: blockId = sbtag[3:2];
        endcase
        return {sbtag[SBTAG_W-1:4], index, blockId, 6'b0};
    endfunction

    // Uncompressed payload of the lowest pending slot, zero-extended.
    function automatic logic [DATA_W-1:0] slotData(
        input logic [3:0]        mask,
        input logic [1:0]        cf,
        input logic [DATA_W-1:0] data
    );
        logic [1:0] k;
        k = lowSlot(mask);
        case (cf)
            2'b01: begin
                if (k == 2'd0) return {{(DATA_W-HALF_W){1'b0}}, data[HALF_W-1:0]};
                else           return {{(DATA_W-HALF_W){1'b0}}, data[DATA_W-1:HALF_W]};
            end
            2'b10: begin
                case (k)
                    2'd0:    return {{(DATA_W-QUAD_W){1'b0}}, data[QUAD_W-1:0]};
                    2'd1:    return {{(DATA_W-QUAD_W){1'b0}}, data[2*QUAD_W-1:QUAD_W]};
                    2'd2:    return {{(DATA_W-QUAD_W){1'b0}}, data[3*QUAD_W-1:2*QUAD_W]};
                    default: return {{(DATA_W-QUAD_W){1'b0}}, data[DATA_W-1:3*QUAD_W]};
                endcase
            end
            default: return data;
        endcase
    endfunction

    // A slot is the last one when it is the only bit left in the mask.
    function automatic logic isSingle(input logic [3:0] mask);
        return (mask != 4'd0) && ((mask & (mask - 4'd1)) == 4'd0);
    endfunction

    // Slot mask of the superblock on the input, by compression class.
    // Class 11 is illegal and produces an empty mask so it is dropped.
    always_comb begin
        w_acc_mask = 4'b0000;
        case (bus.in_cf)
            2'b00:   w_acc_mask = 4'b0001;
            2'b01:   w_acc_mask = {2'b00, bus.in_half_vld[1], bus.in_half_vld[0]};
            2'b10:   w_acc_mask = bus.in_sbtag[3:0];
            default: w_acc_mask = 4'b0000;
        endcase
    end

    // Mask after the current slot is retired: clear the lowest set bit.
    assign w_next_mask = r_mask & (r_mask - 4'd1);

    // Main FSM. IDLE accepts a superblock and either drops it or preloads
    // the first slot onto the registered outputs; EMIT presents slots one
    // at a time and preloads the next slot on each handshake so outputs are
    // stable under backpressure.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_index      <= '0;
            r_sbtag      <= '0;
            r_cf         <= 2'b00;
            r_data       <= '0;
            r_mask       <= 4'b0000;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_addr   <= 32'd0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
            r_wb_count   <= 32'd0;
            r_drop_count <= 16'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_index <= bus.in_index;
                        r_sbtag <= bus.in_sbtag;
                        r_cf    <= bus.in_cf;
                        r_data  <= bus.in_data;
                        r_mask  <= w_acc_mask;
                        if (w_acc_mask != 4'b0000) begin
                            r_state     <= EMIT;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_out_addr  <= slotAddr(w_acc_mask, bus.in_cf, bus.in_sbtag, bus.in_index);
                            r_out_data  <= slotData(w_acc_mask, bus.in_cf, bus.in_data);
                            r_out_last  <= isSingle(w_acc_mask);
                        end else if (r_drop_count != 16'hFFFF) begin
                            r_drop_count <= r_drop_count + 16'd1;
                        end
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        r_wb_count <= r_wb_count + 32'd1;
                        r_mask     <= w_next_mask;
                        if (w_next_mask == 4'b0000) begin
                            r_state     <= IDLE;
                            r_in_ready  <= 1'b1;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                        end else begin
                            r_out_addr <= slotAddr(w_next_mask, r_cf, r_sbtag, r_index);
                            r_out_data <= slotData(w_next_mask, r_cf, r_data);
                            r_out_last <= isSingle(w_next_mask);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_addr  = r_out_addr;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign wb_count      = r_wb_count;
    assign drop_count    = r_drop_count;

endmodule

// File: tb/tb_yacc_sb_writeback_unpacker.sv
// ----------------------------------------------------------------------------
// tb_yacc_sb_writeback_unpacker
//
// Purpose:
//   Self-checking bench for yacc_sb_writeback_unpacker. Stimulus pushes the
//   expected blocks of each superblock into a queue; a monitor pops and
//   compares on every output handshake.
// ----------------------------------------------------------------------------
module tb_yacc_sb_writeback_unpacker;

    localparam int DW = 512;

    typedef struct {
        logic [31:0]   addr;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] wb_count;
    logic [15:0] drop_count;

    yacc_sb_writeback_unpacker_if bus();

    yacc_sb_writeback_unpacker dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .bus        (bus),
        .wb_count   (wb_count),
        .drop_count (drop_count)
    );

    always #5 clock = ~clock;

    beat_t expQ[$];
    int    tests      = 0;
    int    failed     = 0;
    int    expWb      = 0;
    int    expDrop    = 0;
    bit    readyForce = 1'b1;
    bit    monHold    = 1'b0;

    // Generic comparison; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name);
        tests++;
        failed++;
        $display("[TB] FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic logic [DW-1:0] randData();
        logic [DW-1:0] d;
        for (int i = 0; i < DW/32; i++) d[32*i +: 32] = $urandom();
        return d;
    endfunction

    // Reference model: list the live blocks of a superblock as (id, payload)
    // pairs in emission order, then attach addresses and the last flag.
    function automatic int modelPush(input logic [2:0] idx, input logic [24:0] sbtag,
                                     input logic [1:0] cf, input logic [1:0] half,
                                     input logic [DW-1:0] data);
        logic [1:0]    ids[$];
        logic [DW-1:0] payloads[$];
        beat_t         b;
        if (cf == 2'b00) begin
            ids.push_back(sbtag[3:2]);
            payloads.push_back(data);
        end else if (cf == 2'b01) begin
            if (half[0]) begin ids.push_back(sbtag[1:0]); payloads.push_back(data & ((DW'(1) << 256) - 1)); end
            if (half[1]) begin ids.push_back(sbtag[3:2]); payloads.push_back(data >> 256); end
        end else if (cf == 2'b10) begin
            for (int k = 0; k < 4; k++) begin
                if (sbtag[k]) begin
                    ids.push_back(2'(k));
                    payloads.push_back((data >> (128*k)) & ((DW'(1) << 128) - 1));
                end
            end
        end
        for (int i = 0; i < ids.size(); i++) begin
            b.addr = {sbtag[24:4], idx, ids[i], 6'b0};
            b.data = payloads[i];
            b.last = (i == ids.size() - 1);
            expQ.push_back(b);
        end
        if (ids.size() == 0 && expDrop < 65535) expDrop++;
        return ids.size();
    endfunction

    // Offer one superblock, wait for acceptance, then check the first-cycle
    // response (one-cycle output latency, or a drop).
    task automatic applyStimulus(input logic [2:0] idx, input logic [24:0] sbtag,
                                 input logic [1:0] cf, input logic [1:0] half,
                                 input logic [DW-1:0] data);
        int n;
        int waitCyc = 0;
        @(negedge clock);
        while (bus.in_ready !== 1'b1 && waitCyc < 500) begin
            @(negedge clock);
            waitCyc++;
        end
        if (bus.in_ready !== 1'b1) begin
            timeoutFail("in_ready wait");
            return;
        end
        bus.in_valid    = 1'b1;
        bus.in_index    = idx;
        bus.in_sbtag    = sbtag;
        bus.in_cf       = cf;
        bus.in_half_vld = half;
        bus.in_data     = data;
        n = modelPush(idx, sbtag, cf, half, data);
        @(posedge clock);
        #1;
        bus.in_valid    = 1'b0;
        bus.in_index    = 3'($urandom());
        bus.in_sbtag    = 25'($urandom());
        bus.in_cf       = 2'($urandom());
        bus.in_half_vld = 2'($urandom());
        bus.in_data     = randData();
        @(negedge clock);
        if (n > 0) begin
            checkOutput("latency out_valid", DW'(bus.out_valid), DW'(1));
            checkOutput("busy in_ready", DW'(bus.in_ready), DW'(0));
        end else begin
            checkOutput("drop out_valid", DW'(bus.out_valid), DW'(0));
            checkOutput("drop in_ready", DW'(bus.in_ready), DW'(1));
            checkOutput("drop_count", DW'(drop_count), DW'(expDrop));
        end
    endtask

    // Wait until every expected block has been handed off and the unpacker
    // is ready again.
    task automatic waitDrain();
        int cyc = 0;
        @(negedge clock);
        while ((expQ.size() != 0 || bus.in_ready !== 1'b1) && cyc < 2000) begin
            @(negedge clock);
            cyc++;
        end
        if (expQ.size() != 0 || bus.in_ready !== 1'b1) timeoutFail("drain");
    endtask

    // Random backpressure unless a directed test owns out_ready.
    always @(posedge clock) begin
        #1;
        if (!readyForce) bus.out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: compares each handshaken block against the scoreboard, checks
    // output stability under backpressure and the idle cycle after a last beat.
    logic          prevStall = 1'b0;
    logic          idleNext  = 1'b0;
    logic [31:0]   prevAddr;
    logic [DW-1:0] prevData;
    logic          prevLast;
    beat_t         got;

    always @(negedge clock) begin
        if (!reset_n || monHold) begin
            prevStall = 1'b0;
            idleNext  = 1'b0;
        end else begin
            if (idleNext) begin
                checkOutput("post-last in_ready", DW'(bus.in_ready), DW'(1));
                checkOutput("post-last out_valid", DW'(bus.out_valid), DW'(0));
                idleNext = 1'b0;
            end
            if (prevStall) begin
                checkOutput("stall out_valid", DW'(bus.out_valid), DW'(1));
                checkOutput("stall out_addr", DW'(bus.out_addr), DW'(prevAddr));
                checkOutput("stall out_data", bus.out_data, prevData);
                checkOutput("stall out_last", DW'(bus.out_last), DW'(prevLast));
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected beat addr", DW'(bus.out_addr), DW'(0));
                    checkOutput("unexpected beat valid", DW'(bus.out_valid), DW'(0));
                end else begin
                    got = expQ.pop_front();
                    checkOutput("out_addr", DW'(bus.out_addr), DW'(got.addr));
                    checkOutput("out_data", bus.out_data, got.data);
                    checkOutput("out_last", DW'(bus.out_last), DW'(got.last));
                    checkOutput("wb_count", DW'(wb_count), DW'(expWb));
                    expWb++;
                    if (got.last) idleNext = 1'b1;
                end
            end
            prevStall = (bus.out_valid === 1'b1 && bus.out_ready !== 1'b1);
            prevAddr  = bus.out_addr;
            prevData  = bus.out_data;
            prevLast  = bus.out_last;
        end
    end

    initial begin
        logic [DW-1:0] d;
        bus.in_valid    = 1'b0;
        bus.in_index    = '0;
        bus.in_sbtag    = '0;
        bus.in_cf       = '0;
        bus.in_half_vld = '0;
        bus.in_data     = '0;
        bus.out_ready   = 1'b1;
        reset_n         = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;

        // Reset state.
        @(negedge clock);
        checkOutput("reset in_ready", DW'(bus.in_ready), DW'(1));
        checkOutput("reset out_valid", DW'(bus.out_valid), DW'(0));
        checkOutput("reset out_last", DW'(bus.out_last), DW'(0));
        checkOutput("reset out_addr", DW'(bus.out_addr), DW'(0));
        checkOutput("reset out_data", bus.out_data, DW'(0));
        checkOutput("reset wb_count", DW'(wb_count), DW'(0));
        checkOutput("reset drop_count", DW'(drop_count), DW'(0));

        // Uncompressed superblock: one full-line beat.
        applyStimulus(3'd5, {21'h0ABCD, 4'b1000}, 2'b00, 2'b00, randData());
        waitDrain();

        // Class 01, both halves valid.
        applyStimulus(3'd2, {21'h12345, 4'b1001}, 2'b01, 2'b11, randData());
        waitDrain();

        // Class 10 with 5+ cycles of backpressure on the first beat.
        @(posedge clock);
        #1 bus.out_ready = 1'b0;
        applyStimulus(3'd7, {21'h1F00F, 4'b1010}, 2'b10, 2'b00, randData());
        repeat (5) begin
            @(negedge clock);
            checkOutput("stalled wb_count", DW'(wb_count), DW'(expWb));
        end
        @(posedge clock);
        #1 bus.out_ready = 1'b1;
        waitDrain();

        // Drops: illegal class, then class 10 with an empty presence field.
        applyStimulus(3'd1, {21'h00001, 4'b1111}, 2'b11, 2'b11, randData());
        applyStimulus(3'd3, {21'h00002, 4'b0000}, 2'b10, 2'b11, randData());
        checkOutput("drop_count after two drops", DW'(drop_count), DW'(2));

        // Reset during the second beat of a class 01 unpack.
        applyStimulus(3'd4, {21'h0BEEF, 4'b0110}, 2'b01, 2'b11, randData());
        @(posedge clock);
        #1 bus.out_ready = 1'b0;
        @(negedge clock);
        monHold = 1'b1;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        expQ.delete();
        expWb   = 0;
        expDrop = 0;
        @(negedge clock);
        checkOutput("after reset out_valid", DW'(bus.out_valid), DW'(0));
        checkOutput("after reset wb_count", DW'(wb_count), DW'(0));
        checkOutput("after reset in_ready", DW'(bus.in_ready), DW'(1));
        checkOutput("after reset drop_count", DW'(drop_count), DW'(0));
        monHold = 1'b0;
        @(posedge clock);
        #1 bus.out_ready = 1'b1;
        applyStimulus(3'd6, {21'h00ACE, 4'b0100}, 2'b00, 2'b00, randData());
        waitDrain();

        // Randomized superblocks with random backpressure.
        readyForce = 1'b0;
        for (int i = 0; i < 40; i++) begin
            d = randData();
            applyStimulus(3'($urandom()), 25'($urandom()), 2'($urandom()), 2'($urandom()), d);
        end
        waitDrain();
        checkOutput("final wb_count", DW'(wb_count), DW'(expWb));
        checkOutput("final drop_count", DW'(drop_count), DW'(expDrop));
        checkOutput("scoreboard empty", DW'(expQ.size()), DW'(0));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
